// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_HALT  = 2'd3
   } sw_state_e;

   localparam int DEFAULT_CLK_HZ  = 50_000_000;
   localparam int DEFAULT_TICK_HZ = 100;

   // Clock cycles per count tick.
   function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Prescaler width; never below one bit so a divide-by-one build still elaborates.
   function automatic int calc_tick_width(input int clk_hz, input int tick_hz);
      int div;
      div = clk_hz / tick_hz;
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-key and datapath-control bundle between the stopwatch controller and its surroundings.
interface stopwatch_ctrl_if;
   logic       key_reset;
   logic       key_start_pause;
   logic       key_display_stop;
   logic       at_max;
   logic       tick;
   logic       count_clr;
   logic       disp_load;
   logic [1:0] state;
   logic [3:0] led;

   // Board / datapath side: drives keys and the max flag, observes controls.
   modport master (
      output key_reset, key_start_pause, key_display_stop, at_max,
      input  tick, count_clr, disp_load, state, led
   );

   // Controller side.
   modport slave (
      input  key_reset, key_start_pause, key_display_stop, at_max,
      output tick, count_clr, disp_load, state, led
   );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stable-count debouncer and press-edge pulse for one active-low key.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 255
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic key_raw,
   output logic press
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          key_level;
   logic [CW-1:0] stable_cnt;

   // Bring the raw key into the clock domain; reset to the released level.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key_raw;
         sync_2 <= sync_1;
      end
   end

   // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles; pulse on accepted fall.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         key_level  <= 1'b1;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_2 == key_level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            key_level  <= sync_2;
            stable_cnt <= '0;
            press      <= ~sync_2;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key conditioning, IDLE/RUN/PAUSE(/HALT) sequencing, 10 ms tick prescaler.
// Optional build macro STOPWATCH_HALT_EN: stop in HALT at 59:59.99 instead of wrapping.
//
//   state | meaning
//   IDLE  | cleared, waiting for start
//   RUN   | prescaler running, ticks issued
//   PAUSE | prescaler frozen mid-period
//   HALT  | counter saturated at max, only clear leaves
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ          = DEFAULT_CLK_HZ,
   parameter int TICK_HZ         = DEFAULT_TICK_HZ,
   parameter int DEBOUNCE_CYCLES = 255
) (
   input logic              CLOCK_50,
   input logic              reset,
   stopwatch_ctrl_if.slave  sw
);
   localparam int            TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
   localparam int            PW       = calc_tick_width(CLK_HZ, TICK_HZ);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_PAUSE = ST_PAUSE;
   localparam logic [1:0] S_HALT  = ST_HALT;

`ifdef STOPWATCH_HALT_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   logic          clr_press;
   logic          start_press;
   logic          disp_press;
   logic [1:0]    state_q;
   logic [PW-1:0] prescaler;
   logic          count_clr_q;
   logic          disp_load_q;
   logic          period_end;
   logic          halt_now;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
      .CLOCK_50 (CLOCK_50), .reset (reset), .key_raw (sw.key_reset), .press (clr_press)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
      .CLOCK_50 (CLOCK_50), .reset (reset), .key_raw (sw.key_start_pause), .press (start_press)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_disp (
      .CLOCK_50 (CLOCK_50), .reset (reset), .key_raw (sw.key_display_stop), .press (disp_press)
   );

   // A saturated counter turns the period boundary into a HALT instead of a tick.
   assign period_end = (state_q == S_RUN) && (prescaler == PRE_LAST);
   assign halt_now   = period_end && sw.at_max && HALT_EN;

   // Sequencing: clear beats everything, display toggles alongside any start action.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_clr_q <= 1'b0;
         disp_load_q <= 1'b1;
      end else begin
         count_clr_q <= 1'b0;
         if (clr_press) begin
            state_q     <= S_IDLE;
            count_clr_q <= 1'b1;
            disp_load_q <= 1'b1;
         end else begin
            if (disp_press) disp_load_q <= ~disp_load_q;
            case (state_q)
               S_IDLE:  if (start_press) state_q <= S_RUN;
               S_RUN: begin
                  if (halt_now)         state_q <= S_HALT;
                  else if (start_press) state_q <= S_PAUSE;
               end
               S_PAUSE: if (start_press) state_q <= S_RUN;
               default: state_q <= state_q;
            endcase
         end
      end
   end

   // Prescaler advances only in RUN and holds elsewhere so a resume keeps the partial period.
   always_ff @(posedge CLOCK_50) begin
      if (reset || clr_press) begin
         prescaler <= '0;
      end else if (state_q == S_RUN) begin
         prescaler <= period_end ? '0 : prescaler + PW'(1);
      end
   end

   assign sw.tick      = period_end && !halt_now;
   assign sw.count_clr = count_clr_q;
   assign sw.disp_load = disp_load_q;
   assign sw.state     = state_q;
   assign sw.led       = {HALT_EN && (state_q == S_HALT), disp_load_q,
                          state_q == S_PAUSE, state_q == S_RUN};
endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   logic CLOCK_50 = 1'b0;
   logic reset;
   stopwatch_ctrl_if sw_if ();

   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .sw       (sw_if)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int exp_tick_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   // Tick scoreboard: every tick must match the next scheduled cycle, in RUN, without a clear.
   always @(negedge CLOCK_50) begin
      if (sw_if.tick === 1'b1) begin
         n_checks++;
         assert (exp_tick_q.size() != 0) else begin
            n_errors++;
            $error("FAIL tick_unexpected: observed tick at cycle %0d expected none", cyc);
         end
         if (exp_tick_q.size() != 0) chk("tick_cycle", cyc, exp_tick_q.pop_front());
         chk("tick_in_run", sw_if.state, ST_RUN);
         chk("tick_without_clr", sw_if.count_clr, 1'b0);
      end
   end

   int g, t, v, w, x, y, y2, z, q, r0;

   initial begin
      reset = 1'b1;
      sw_if.key_reset        = 1'b1;
      sw_if.key_start_pause  = 1'b1;
      sw_if.key_display_stop = 1'b1;
      sw_if.at_max           = 1'b0;

      // Reset values
      wait_until(3);
      chk("rst_state", sw_if.state, ST_IDLE);
      chk("rst_tick", sw_if.tick, 1'b0);
      chk("rst_count_clr", sw_if.count_clr, 1'b0);
      chk("rst_disp_load", sw_if.disp_load, 1'b1);
      chk("rst_led", sw_if.led, 4'b0100);
      reset = 1'b0;

      // Short bounces never reach the debounce threshold
      g = 5;
      wait_until(g);     sw_if.key_start_pause = 1'b0;
      wait_until(g + 3); sw_if.key_start_pause = 1'b1;
      wait_until(g + 4); sw_if.key_start_pause = 1'b0;
      wait_until(g + 7); sw_if.key_start_pause = 1'b1;
      wait_until(g + 14);
      chk("glitch_state_idle", sw_if.state, ST_IDLE);
      chk("glitch_led", sw_if.led, 4'b0100);

      // Start from IDLE, periodic ticks
      t = 22;
      exp_tick_q.push_back(t + 16);
      exp_tick_q.push_back(t + 26);
      exp_tick_q.push_back(t + 36);
      wait_until(t);     sw_if.key_start_pause = 1'b0;
      wait_until(t + 6); chk("start_before_effect", sw_if.state, ST_IDLE);
      wait_until(t + 7);
      chk("start_state_run", sw_if.state, ST_RUN);
      chk("start_led", sw_if.led, 4'b0101);
      wait_until(t + 8); sw_if.key_start_pause = 1'b1;

      // Pause with prescaler at 5 in the press cycle, hold 50 cycles, resume
      wait_until(t + 36); sw_if.key_start_pause = 1'b0;
      wait_until(t + 42); chk("pause_before_effect", sw_if.state, ST_RUN);
      wait_until(t + 43);
      chk("pause_state", sw_if.state, ST_PAUSE);
      chk("pause_led", sw_if.led, 4'b0110);
      wait_until(t + 44); sw_if.key_start_pause = 1'b1;
      v = t + 93;
      exp_tick_q.push_back(v + 10);
      exp_tick_q.push_back(v + 20);
      wait_until(v);      sw_if.key_start_pause = 1'b0;
      wait_until(v + 7);  chk("resume_state_run", sw_if.state, ST_RUN);
      wait_until(v + 8);  sw_if.key_start_pause = 1'b1;

      // Clear and start together in RUN
      w = v + 22;
      wait_until(w);
      sw_if.key_reset = 1'b0;
      sw_if.key_start_pause = 1'b0;
      wait_until(w + 6);
      chk("clr_before_state", sw_if.state, ST_RUN);
      chk("clr_before_pulse", sw_if.count_clr, 1'b0);
      wait_until(w + 7);
      chk("clr_state_idle", sw_if.state, ST_IDLE);
      chk("clr_pulse", sw_if.count_clr, 1'b1);
      chk("clr_tick", sw_if.tick, 1'b0);
      wait_until(w + 8);
      chk("clr_pulse_one_cycle", sw_if.count_clr, 1'b0);
      sw_if.key_reset = 1'b1;
      sw_if.key_start_pause = 1'b1;

      // Display toggles twice in IDLE
      x = w + 16;
      wait_until(x);     sw_if.key_display_stop = 1'b0;
      wait_until(x + 6); chk("disp1_before", sw_if.disp_load, 1'b1);
      wait_until(x + 7);
      chk("disp1_frozen", sw_if.disp_load, 1'b0);
      chk("disp1_led", sw_if.led, 4'b0000);
      chk("disp1_state", sw_if.state, ST_IDLE);
      wait_until(x + 8); sw_if.key_display_stop = 1'b1;
      y = x + 16;
      wait_until(y);     sw_if.key_display_stop = 1'b0;
      wait_until(y + 7);
      chk("disp2_live", sw_if.disp_load, 1'b1);
      chk("disp2_led", sw_if.led, 4'b0100);
      wait_until(y + 8); sw_if.key_display_stop = 1'b1;

      // Clear and display together: display press discarded
      y2 = y + 16;
      wait_until(y2);
      sw_if.key_reset = 1'b0;
      sw_if.key_display_stop = 1'b0;
      wait_until(y2 + 7);
      chk("clrdisp_pulse", sw_if.count_clr, 1'b1);
      chk("clrdisp_disp_load", sw_if.disp_load, 1'b1);
      chk("clrdisp_state", sw_if.state, ST_IDLE);
      wait_until(y2 + 8);
      sw_if.key_reset = 1'b1;
      sw_if.key_display_stop = 1'b1;

      // Start and display together, with the datapath at max
      z = y2 + 16;
`ifndef STOPWATCH_HALT_EN
      exp_tick_q.push_back(z + 16);
      exp_tick_q.push_back(z + 26);
      exp_tick_q.push_back(z + 36);
`endif
      wait_until(z);
      sw_if.at_max = 1'b1;
      sw_if.key_start_pause = 1'b0;
      sw_if.key_display_stop = 1'b0;
      wait_until(z + 7);
      chk("startdisp_state", sw_if.state, ST_RUN);
      chk("startdisp_disp_load", sw_if.disp_load, 1'b0);
      chk("startdisp_led", sw_if.led, 4'b0001);
      wait_until(z + 8);
      sw_if.key_start_pause = 1'b1;
      sw_if.key_display_stop = 1'b1;
      wait_until(z + 17);
`ifdef STOPWATCH_HALT_EN
      chk("halt_state", sw_if.state, ST_HALT);
      chk("halt_led", sw_if.led, 4'b1000);
      wait_until(z + 18); sw_if.key_start_pause = 1'b0;
      wait_until(z + 25); chk("halt_ignores_start", sw_if.state, ST_HALT);
      wait_until(z + 26); sw_if.key_start_pause = 1'b1;
`else
      chk("atmax_ignored_state", sw_if.state, ST_RUN);
      chk("atmax_ignored_led", sw_if.led, 4'b0001);
`endif

      // Clear from the active state
      q = z + 30;
      wait_until(q); sw_if.key_reset = 1'b0;
      wait_until(q + 7);
      chk("final_clr_state", sw_if.state, ST_IDLE);
      chk("final_clr_pulse", sw_if.count_clr, 1'b1);
      chk("final_clr_led", sw_if.led, 4'b0100);
      wait_until(q + 8);
      sw_if.key_reset = 1'b1;
      sw_if.at_max = 1'b0;

      // Synchronous reset in RUN while keys are held down
      r0 = q + 16;
      wait_until(r0);      sw_if.key_start_pause = 1'b0;
      wait_until(r0 + 7);  chk("rerun_state", sw_if.state, ST_RUN);
      wait_until(r0 + 8);  sw_if.key_start_pause = 1'b1;
      wait_until(r0 + 10);
      sw_if.key_reset = 1'b0;
      sw_if.key_display_stop = 1'b0;
      wait_until(r0 + 12); reset = 1'b1;
      wait_until(r0 + 13);
      chk("midrst_state", sw_if.state, ST_IDLE);
      chk("midrst_led", sw_if.led, 4'b0100);
      chk("midrst_count_clr", sw_if.count_clr, 1'b0);
      chk("midrst_tick", sw_if.tick, 1'b0);
      wait_until(r0 + 15);
      reset = 1'b0;
      sw_if.key_reset = 1'b1;
      sw_if.key_display_stop = 1'b1;
      wait_until(r0 + 40);
      chk("post_rst_state", sw_if.state, ST_IDLE);
      chk("post_rst_disp_load", sw_if.disp_load, 1'b1);
      chk("ticks_outstanding", exp_tick_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
